amax10_qsys_key_pio: RTL and testbench
======================================

AMAX10_QSYS_KEY_PIO -- requirements
Module: amax10_qsys_key_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the number of input pins (1..32).
REQ-002 The block SHALL have parameter EDGE_TYPE, default 1, which selects edge detection: 0 rising, 1 falling, 2 any.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 1, which sets the per-bit reset value of the synchronizer, filter and previous-value registers.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, which sets the number of consecutive stable cycles required before a filtered bit changes.
REQ-005 The block SHALL have port clk, input, width 1: clock.
REQ-006 The block SHALL have port reset_n, input, width 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port address, input, width 2: Avalon-MM word address.
REQ-008 The block SHALL have port chipselect, input, width 1: Avalon-MM slave select.
REQ-009 The block SHALL have port write_n, input, width 1: active-low write strobe.
REQ-010 The block SHALL have port writedata, input, width 32: write data.
REQ-011 The block SHALL have port readdata, output, width 32: registered read data.
REQ-012 The block SHALL have port in_port, input, width WIDTH: asynchronous key/switch inputs.
REQ-013 The block SHALL have port irq, output, width 1: level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-015 Filtered value filt SHALL equal sync2 delayed through the debounce stage (see Configuration); prev SHALL register filt every cycle.
REQ-016 Register map SHALL be:
- addr 0: data, read-only, value filt.
- addr 1: reserved, reads 0.
- addr 2: irqmask, RW, WIDTH bits.
- addr 3: edgecapture, read / write-1-to-clear.
REQ-017 A write SHALL occur when chipselect=1 and write_n=0; writes to addr 0/1 SHALL be ignored, and writedata[31:WIDTH] SHALL be ignored.
REQ-018 readdata SHALL be registered every clk from the current address, independent of chipselect: 1-cycle read latency, 0 wait states, bits [31:WIDTH] = 0.
REQ-019 Edge detection per bit SHALL be:
- rising: filt & ~prev
- falling: ~filt & prev
- any: filt ^ prev
REQ-020 A detected edge SHALL set the corresponding edgecapture bit at the next clk edge; the bit SHALL stay set until cleared.
REQ-021 Writing addr 3 SHALL clear each edgecapture bit whose writedata bit is 1 and leave the others unchanged.
REQ-022 When an edge and a clear hit the same bit in the same cycle, set SHALL win.
REQ-023 irq SHALL be combinational: |(edgecapture & irqmask).
REQ-024 Latency without debounce: an in_port change stable before clk edge N SHALL appear at:
- sync2 at N+1;
- edgecapture and readdata(addr 0) at N+2;
- irq during the cycle after N+2.

Reset
REQ-025 While reset_n=0, the following SHALL apply:
- sync1, sync2, filt and prev = {WIDTH{IDLE_LEVEL}};
- irqmask = 0, edgecapture = 0, readdata = 0, irq = 0;
- debounce counters = 0.
REQ-026 Deassertion of reset SHALL NOT create an edge when in_port is at IDLE_LEVEL; reset applied mid-operation SHALL discard pending captures immediately.

Configuration
REQ-027 Macro AMAX10_QSYS_KEY_PIO_DEBOUNCE_EN SHALL select the debounce behaviour.
REQ-028 With the macro defined, each bit SHALL behave as follows:
- The counter (width clog2(DEBOUNCE_CYCLES+1)) increments while sync2 != filt and resets to 0 when they are equal.
- When the counter = DEBOUNCE_CYCLES-1 and sync2 != filt, filt <= sync2 and the counter clears.
- filt therefore follows at N+1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES produces no change.
REQ-029 Without the macro, filt SHALL equal sync2 (a wire), no counters SHALL exist, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-030 Package amax10_qsys_pio_pkg SHALL hold:
- address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
- edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
REQ-031 Per-bit debounce SHALL be sub-module amax10_qsys_debounce (params DEBOUNCE_CYCLES and IDLE_LEVEL), instantiated WIDTH times under the macro.

Verification
REQ-032 The bench SHALL run the reset default test: release reset with in_port=4'hF, then read addr 0, 2 and 3 -> 32'h0000000F, 0, 0; irq=0 throughout.
REQ-033 The bench SHALL run the falling-edge IRQ test: write irqmask=4'h2, drive in_port[1] 1->0 -> edgecapture reads 4'h2 and irq=1; write 4'h2 to addr 3 -> edgecapture=0 and irq=0.
REQ-034 The bench SHALL run the masked edge test: irqmask=0, toggle in_port[0] low -> edgecapture=4'h1 and irq stays 0; writing addr 0 with 32'hFFFFFFFF has no effect on data.
REQ-035 The bench SHALL run the simultaneous set/clear test: schedule a bit-2 falling edge to capture in the same cycle as a clear write of 4'h4 -> bit 2 remains 1.
REQ-036 The bench SHALL run the debounce test with the macro defined and DEBOUNCE_CYCLES=8: a 5-cycle low pulse on in_port[3] -> no data change and no capture; a 20-cycle low -> data bit 3 = 0 exactly 9 cycles after sync2 changes, and edgecapture bit 3 is set.
REQ-037 The bench SHALL run the read latency test: change address 0->2 -> readdata reflects irqmask on the next clk edge.

Source files
------------

// File: rtl/amax10_qsys_pio_pkg.sv
// Shared constants for the Avalon-MM key/switch PIO: register map and edge-type encodings.
package amax10_qsys_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/amax10_qsys_debounce.sv
// Single-bit debounce filter: output follows the input only after it has
// differed from the output for DEBOUNCE_CYCLES consecutive clocks.
module amax10_qsys_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Any return to agreement restarts the count, so short glitches never propagate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= IDLE_LEVEL;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/amax10_qsys_key_pio.sv
// Avalon-MM input PIO for keys/switches with edge capture and level IRQ.
// Define AMAX10_QSYS_KEY_PIO_DEBOUNCE_EN to insert a per-bit debounce filter after the synchronizer.
module amax10_qsys_key_pio
    import amax10_qsys_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1, sync2, filt, prev;
    logic [WIDTH-1:0] irqmask, edgecapture, edges, wdata_bits;
    logic [31:0]      rd_next;
    logic             wr_en;

    assign wr_en      = chipselect & ~write_n;
    assign wdata_bits = writedata[WIDTH-1:0];

    // Upper write-data bits carry no meaning for this peripheral.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef AMAX10_QSYS_KEY_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        amax10_qsys_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (sync2[i]),
            .dout    (filt[i])
        );
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign filt = sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= IDLE_VEC;
        else          prev <= filt;
    end

    always_comb begin
        edges = ~filt & prev;
        case (EDGE_TYPE)
            EDGE_RISE: edges = filt & ~prev;
            EDGE_ANY:  edges = filt ^ prev;
            default:   edges = ~filt & prev;
        endcase
    end

    // Clear is applied first and new edges OR'd on top, so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK)
                irqmask <= wdata_bits;
            if (wr_en && address == ADDR_EDGECAP)
                edgecapture <= (edgecapture & ~wdata_bits) | edges;
            else
                edgecapture <= edgecapture | edges;
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_amax10_qsys_key_pio.sv
// Self-checking bench for amax10_qsys_key_pio (falling-edge, idle-high, 4 keys).
// Debounce checks run when AMAX10_QSYS_KEY_PIO_DEBOUNCE_EN is defined.
module tb_amax10_qsys_key_pio;

    localparam int WIDTH = 4;
    localparam int DC    = 8;
`ifdef AMAX10_QSYS_KEY_PIO_DEBOUNCE_EN
    localparam int FILT_LAT = 1 + DC;
`else
    localparam int FILT_LAT = 1;
`endif
    localparam int SETTLE = FILT_LAT + 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port = '1;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] keys_m, mask_m, ecap_m;

    amax10_qsys_key_pio #(
        .WIDTH           (WIDTH),
        .EDGE_TYPE       (1),
        .IDLE_LEVEL      (1'b1),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 32'h%08h, want 32'h%08h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_port = '1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        pulse_leak;
        logic [31:0] wd;
        logic [WIDTH-1:0] nk;
        int          op;

        // Reset defaults
        repeat (2) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        bus_read(2'd0, rd); check("rst_data", rd, 32'h0000000F);
        bus_read(2'd2, rd); check("rst_irqmask", rd, 32'h0);
        bus_read(2'd3, rd); check("rst_edgecap", rd, 32'h0);
        check("rst_irq_after", {31'd0, irq}, 32'h0);

        // Falling-edge IRQ and write-1-to-clear
        bus_write(2'd2, 32'h2);
        @(negedge clk); in_port[1] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        bus_read(2'd3, rd); check("fall_edgecap", rd, 32'h2);
        check("fall_irq", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd); check("clr_edgecap", rd, 32'h0);
        check("clr_irq", {31'd0, irq}, 32'h0);
        @(negedge clk); in_port[1] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus_read(2'd3, rd); check("rise_ignored", rd, 32'h0);

        // Masked edge and writes to read-only addresses
        bus_write(2'd2, 32'h0);
        @(negedge clk); in_port[0] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        bus_read(2'd3, rd); check("mask_edgecap", rd, 32'h1);
        check("mask_irq", {31'd0, irq}, 32'h0);
        bus_write(2'd0, 32'hFFFFFFFF);
        bus_read(2'd0, rd); check("ro_data", rd, 32'h0000000E);
        bus_write(2'd1, 32'hFFFFFFFF);
        bus_read(2'd1, rd); check("rsvd_zero", rd, 32'h0);
        bus_write(2'd2, 32'hFFFFFFF0);
        bus_read(2'd2, rd); check("mask_upper_ignored", rd, 32'h0);
        @(negedge clk); in_port[0] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus_write(2'd3, 32'hF);

        // Input-to-readdata/irq latency, then address switch latency
        bus_write(2'd2, 32'h8);
        @(negedge clk);
        address = 2'd0; chipselect = 1'b0;
        in_port[3] = 1'b0;
        repeat (FILT_LAT + 1) @(negedge clk);
        check("lat_data_old", readdata, 32'h0000000F);
        check("lat_irq_old", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("lat_data_new", readdata, 32'h00000007);
        check("lat_irq_new", {31'd0, irq}, 32'h1);
        address = 2'd2;
        @(negedge clk);
        check("addr_switch", readdata, 32'h8);
        bus_write(2'd3, 32'hF);
        @(negedge clk); in_port[3] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h0);

        // Set and clear landing on the same edge
        bus_read(2'd3, rd); check("sim_pre", rd, 32'h0);
        @(negedge clk); in_port[2] = 1'b0;
        repeat (1 + FILT_LAT) @(negedge clk);
        address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        bus_read(2'd3, rd); check("set_wins", rd, 32'h4);
        @(negedge clk); in_port[2] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus_write(2'd3, 32'hF);

        // Reset mid-operation drops pending captures at once
        bus_write(2'd2, 32'hF);
        @(negedge clk); in_port[1] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        @(negedge clk);
        reset_n = 1'b0; in_port = '1;
        #1;
        check("async_rst_irq", {31'd0, irq}, 32'h0);
        check("async_rst_rd", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus_read(2'd3, rd); check("post_rst_edgecap", rd, 32'h0);
        bus_read(2'd2, rd); check("post_rst_irqmask", rd, 32'h0);

`ifdef AMAX10_QSYS_KEY_PIO_DEBOUNCE_EN
        // Short glitch rejected; long low accepted exactly 9 cycles after sync2 moves
        @(negedge clk);
        address = 2'd0; chipselect = 1'b0;
        pulse_leak = 1'b0;
        in_port[3] = 1'b0;
        repeat (5) @(negedge clk);
        in_port[3] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (readdata !== 32'h0000000F) pulse_leak = 1'b1;
        end
        check("db_glitch_data", {31'd0, pulse_leak}, 32'h0);
        bus_read(2'd3, rd); check("db_glitch_cap", rd, 32'h0);
        @(negedge clk);
        address = 2'd0; chipselect = 1'b0;
        in_port[3] = 1'b0;
        repeat (10) @(negedge clk);
        check("db_data_before", readdata, 32'h0000000F);
        @(negedge clk);
        check("db_data_after", readdata, 32'h00000007);
        repeat (9) @(negedge clk);
        in_port[3] = 1'b1;
        bus_read(2'd3, rd); check("db_cap", rd, 32'h8);
        repeat (SETTLE) @(negedge clk);
        bus_write(2'd3, 32'hF);
`endif

        // Randomized register/key traffic against a transaction-level model
        do_reset();
        keys_m = '1; mask_m = '0; ecap_m = '0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            wd = $urandom;
            case (op)
                0: begin
                    nk = wd[WIDTH-1:0];
                    @(negedge clk); in_port = nk;
                    repeat (SETTLE) @(negedge clk);
                    ecap_m = ecap_m | (keys_m & ~nk);
                    keys_m = nk;
                end
                1: begin
                    bus_write(2'd2, wd);
                    mask_m = wd[WIDTH-1:0];
                end
                2: begin
                    bus_write(2'd3, wd);
                    ecap_m = ecap_m & ~wd[WIDTH-1:0];
                end
                default: bus_write(wd[4] ? 2'd1 : 2'd0, wd);
            endcase
            bus_read(2'd0, rd); check("rnd_data", rd, {28'd0, keys_m});
            bus_read(2'd1, rd); check("rnd_rsvd", rd, 32'h0);
            bus_read(2'd2, rd); check("rnd_irqmask", rd, {28'd0, mask_m});
            bus_read(2'd3, rd); check("rnd_edgecap", rd, {28'd0, ecap_m});
            check("rnd_irq", {31'd0, irq}, {31'd0, |(ecap_m & mask_m)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
